// File: rtl/lsu_pkg.sv
// Shared load/store definitions: access sizes, bridge FSM states and
// helpers for byte-mask generation and alignment checking.
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_e;

  function automatic logic [7:0] size_to_mask(input logic [1:0] size);
    logic [7:0] mask;
    case (size)
      SZ_B:    mask = 8'h01;
      SZ_H:    mask = 8'h03;
      SZ_W:    mask = 8'h0F;
      SZ_D:    mask = 8'hFF;
      default: mask = 8'hFF;
    endcase
    return mask;
  endfunction

  // Only the low three address bits can make a naturally-aligned access misaligned.
  function automatic logic is_misaligned(input logic [2:0] addr_lo, input logic [1:0] size);
    logic mis;
    case (size)
      SZ_B:    mis = 1'b0;
      SZ_H:    mis = (addr_lo[0] != 1'b0);
      SZ_W:    mis = (addr_lo[1:0] != 2'b00);
      SZ_D:    mis = (addr_lo != 3'b000);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Sizes right-justified raw load data and sign- or zero-extends it to 64 bits.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [63:0] raw_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  output logic [63:0] out_o
);

  always_comb begin
    out_o = raw_i;
    case (size_i)
      SZ_B:    out_o = {{56{signed_i & raw_i[7]}},  raw_i[7:0]};
      SZ_H:    out_o = {{48{signed_i & raw_i[15]}}, raw_i[15:0]};
      SZ_W:    out_o = {{32{signed_i & raw_i[31]}}, raw_i[31:0]};
      SZ_D:    out_o = raw_i;
      default: out_o = raw_i;
    endcase
  end

endmodule

// File: rtl/dpic_lsu_bridge.sv
// Single-outstanding load/store front-end for the DPI-C memory model: one
// memory cycle per request, misaligned requests answered without touching memory.
module dpic_lsu_bridge
  import lsu_pkg::*;
#(
  parameter int               XLEN     = 64,
  parameter logic [XLEN-1:0]  ERR_DATA = {XLEN{1'b0}}
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_wr,
  input  logic [1:0]      req_size,
  input  logic            req_signed,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic            mem_rd_en,
  output logic [XLEN-1:0] mem_rd_addr,
  input  logic [XLEN-1:0] mem_rd_data,
  output logic            mem_we_en,
  output logic [XLEN-1:0] mem_we_addr,
  output logic [XLEN-1:0] mem_we_data,
  output logic [7:0]      mem_we_mask
);

  lsu_state_e      state_q, state_d;
  logic            wr_q;
  logic [1:0]      size_q;
  logic            signed_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] rdata_q;
  logic            err_q;

  logic            accept_s;
  logic            mis_s;
  logic [63:0]     load_data_s;

  assign req_ready  = (state_q == IDLE);
  assign accept_s   = req_valid & req_ready;
  assign mis_s      = is_misaligned(req_addr[2:0], req_size);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  lsu_load_align u_align (
    .raw_i    (mem_rd_data),
    .size_i   (size_q),
    .signed_i (signed_q),
    .out_o    (load_data_s)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d = mis_s ? RESP : ACCESS;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: state_d = RESP;
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      wr_q     <= 1'b0;
      size_q   <= SZ_B;
      signed_q <= 1'b0;
      addr_q   <= {XLEN{1'b0}};
      wdata_q  <= {XLEN{1'b0}};
      rdata_q  <= {XLEN{1'b0}};
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept_s) begin
        wr_q     <= req_wr;
        size_q   <= req_size;
        signed_q <= req_signed;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        err_q    <= mis_s;
        rdata_q  <= mis_s ? ERR_DATA : {XLEN{1'b0}};
      end else if (state_q == ACCESS) begin
        rdata_q <= wr_q ? {XLEN{1'b0}} : load_data_s;
      end else begin
        rdata_q <= rdata_q;
      end
    end
  end

  // Memory ports are decoded from registered state only and forced to zero outside ACCESS.
  always_comb begin
    mem_rd_en   = 1'b0;
    mem_rd_addr = {XLEN{1'b0}};
    mem_we_en   = 1'b0;
    mem_we_addr = {XLEN{1'b0}};
    mem_we_data = {XLEN{1'b0}};
    mem_we_mask = 8'h00;
    if (state_q == ACCESS) begin
      if (wr_q) begin
        mem_we_en   = 1'b1;
        mem_we_addr = addr_q;
        mem_we_data = wdata_q;
        mem_we_mask = size_to_mask(size_q);
      end else begin
        mem_rd_en   = 1'b1;
        mem_rd_addr = addr_q;
      end
    end else begin
      mem_rd_en = 1'b0;
    end
  end

endmodule

// File: tb/tb_dpic_lsu_bridge.sv
// Directed scoreboard bench for dpic_lsu_bridge with a combinational memory model.
module tb_dpic_lsu_bridge;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_wr, req_signed;
  logic [1:0]  req_size;
  logic [63:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [63:0] resp_rdata;
  logic        mem_rd_en, mem_we_en;
  logic [63:0] mem_rd_addr, mem_rd_data, mem_we_addr, mem_we_data;
  logic [7:0]  mem_we_mask;

  logic [63:0] model_val;
  int          rd_pulses, we_pulses;
  logic [63:0] last_rd_addr, last_we_addr, last_we_data;
  logic [7:0]  last_we_mask;
  int          vectors = 0;
  int          miscompares = 0;
  exp_t        sb[$];

  always #5 clock = ~clock;

  assign mem_rd_data = mem_rd_en ? model_val : 64'hA5A5_5A5A_A5A5_5A5A;

  dpic_lsu_bridge dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_rd_en(mem_rd_en),
    .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data), .mem_we_en(mem_we_en),
    .mem_we_addr(mem_we_addr), .mem_we_data(mem_we_data), .mem_we_mask(mem_we_mask)
  );

  always @(posedge clock) begin
    if (mem_rd_en) begin
      rd_pulses    <= rd_pulses + 1;
      last_rd_addr <= mem_rd_addr;
    end
    if (mem_we_en) begin
      we_pulses    <= we_pulses + 1;
      last_we_addr <= mem_we_addr;
      last_we_data <= mem_we_data;
      last_we_mask <= mem_we_mask;
    end
    if (mem_rd_en && mem_we_en) begin
      $display("FAIL rd_we_both observed=1 expected=0");
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request from a negedge, return at the negedge where resp_valid is seen.
  task automatic issue(input logic wr, input logic [1:0] size, input logic sgn,
                       input logic [63:0] addr, input logic [63:0] wdata, output int lat);
    chk("req_ready_idle", {63'd0, req_ready}, 64'd1);
    req_valid = 1'b1; req_wr = wr; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata;
    @(posedge clock);
    #1 req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clock);
      lat++;
    end while (!resp_valid && lat < 8);
  endtask

  task automatic finish_resp(input string tag, input int lat, input int exp_lat);
    exp_t e;
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_valid"}, {63'd0, resp_valid}, 64'd1);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_rdata"}, resp_rdata, e.rdata);
      chk({tag, "_err"}, {63'd0, resp_err}, {63'd0, e.err});
    end
    @(posedge clock);
    @(negedge clock);
    chk({tag, "_back_idle"}, {62'd0, resp_valid, req_ready}, 64'd1);
  endtask

  task automatic do_load(input string tag, input logic [1:0] size, input logic sgn,
                         input logic [63:0] addr, input logic [63:0] raw,
                         input logic [63:0] exp_rdata);
    int lat;
    rd_pulses = 0; we_pulses = 0;
    model_val = raw;
    sb.push_back('{exp_rdata, 1'b0});
    issue(1'b0, size, sgn, addr, 64'h0, lat);
    chk({tag, "_rd_pulses"}, 64'(rd_pulses), 64'd1);
    chk({tag, "_we_pulses"}, 64'(we_pulses), 64'd0);
    chk({tag, "_rd_addr"}, last_rd_addr, addr);
    finish_resp(tag, lat, 2);
  endtask

  initial begin
    int lat;
    exp_t e;
    reset = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 64'h0; req_wdata = 64'h0; resp_ready = 1'b1; model_val = 64'h0;
    rd_pulses = 0; we_pulses = 0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    chk("rst_ready", {63'd0, req_ready}, 64'd1);
    chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("rst_resp_err", {63'd0, resp_err}, 64'd0);
    chk("rst_resp_rdata", resp_rdata, 64'd0);
    chk("rst_mem_en", {62'd0, mem_rd_en, mem_we_en}, 64'd0);
    chk("rst_mem_bus", mem_rd_addr | mem_we_addr | mem_we_data | {56'd0, mem_we_mask}, 64'd0);

    do_load("ld_d", 2'd3, 1'b1, 64'h0000_0000_8000_0000, 64'h1122_3344_5566_7788,
            64'h1122_3344_5566_7788);
    do_load("ld_b_s", 2'd0, 1'b1, 64'h0000_0000_8000_0003, 64'h1234_5678_9ABC_DE80,
            64'hFFFF_FFFF_FFFF_FF80);
    do_load("ld_b_u", 2'd0, 1'b0, 64'h0000_0000_8000_0003, 64'h1234_5678_9ABC_DE80,
            64'h0000_0000_0000_0080);
    do_load("ld_h_s", 2'd1, 1'b1, 64'h0000_0000_8000_0002, 64'h0000_0000_0000_8001,
            64'hFFFF_FFFF_FFFF_8001);
    do_load("ld_w_s", 2'd2, 1'b1, 64'h0000_0000_8000_0004, 64'h1234_5678_8765_4321,
            64'hFFFF_FFFF_8765_4321);
    do_load("ld_w_u", 2'd2, 1'b0, 64'h0000_0000_8000_0004, 64'h1234_5678_8765_4321,
            64'h0000_0000_8765_4321);
    do_load("ld_wrap", 2'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'hFEDC_BA98_7654_3210,
            64'hFEDC_BA98_7654_3210);

    // Store W
    rd_pulses = 0; we_pulses = 0;
    sb.push_back('{64'h0, 1'b0});
    issue(1'b1, 2'd2, 1'b0, 64'h0000_0000_8000_0010, 64'h0000_0000_DEAD_BEEF, lat);
    chk("st_w_we_pulses", 64'(we_pulses), 64'd1);
    chk("st_w_rd_pulses", 64'(rd_pulses), 64'd0);
    chk("st_w_mask", {56'd0, last_we_mask}, 64'h0F);
    chk("st_w_addr", last_we_addr, 64'h0000_0000_8000_0010);
    chk("st_w_data", last_we_data, 64'h0000_0000_DEAD_BEEF);
    finish_resp("st_w", lat, 2);

    // Store B and D masks
    rd_pulses = 0; we_pulses = 0;
    sb.push_back('{64'h0, 1'b0});
    issue(1'b1, 2'd0, 1'b0, 64'h0000_0000_8000_0021, 64'h0000_0000_0000_00AB, lat);
    chk("st_b_mask", {56'd0, last_we_mask}, 64'h01);
    finish_resp("st_b", lat, 2);
    sb.push_back('{64'h0, 1'b0});
    issue(1'b1, 2'd3, 1'b0, 64'h0000_0000_8000_0028, 64'h0102_0304_0506_0708, lat);
    chk("st_d_mask", {56'd0, last_we_mask}, 64'hFF);
    chk("st_d_data", last_we_data, 64'h0102_0304_0506_0708);
    finish_resp("st_d", lat, 2);

    // Misaligned loads/stores never reach memory
    rd_pulses = 0; we_pulses = 0;
    sb.push_back('{64'h0, 1'b1});
    issue(1'b0, 2'd1, 1'b1, 64'h0000_0000_8000_0001, 64'h0, lat);
    chk("mis_h_pulses", 64'(rd_pulses + we_pulses), 64'd0);
    finish_resp("mis_h", lat, 1);
    sb.push_back('{64'h0, 1'b1});
    issue(1'b1, 2'd3, 1'b0, 64'h0000_0000_8000_0004, 64'h1111, lat);
    chk("mis_d_pulses", 64'(rd_pulses + we_pulses), 64'd0);
    finish_resp("mis_d", lat, 1);

    // Backpressure: response held for 5 cycles, second request ignored
    resp_ready = 1'b0;
    rd_pulses = 0; we_pulses = 0;
    model_val = 64'h0000_0000_0000_0080;
    sb.push_back('{64'h0000_0000_0000_0080, 1'b0});
    issue(1'b0, 2'd0, 1'b0, 64'h0000_0000_8000_0003, 64'h0, lat);
    chk("bp_latency", 64'(lat), 64'd2);
    e = sb.pop_front();
    req_valid = 1'b1; req_wr = 1'b1; req_size = 2'd3; req_addr = 64'h0000_0000_8000_0040;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock);
      @(negedge clock);
      chk("bp_valid", {63'd0, resp_valid}, 64'd1);
      chk("bp_rdata", resp_rdata, e.rdata);
      chk("bp_err", {63'd0, resp_err}, {63'd0, e.err});
      chk("bp_req_ready", {63'd0, req_ready}, 64'd0);
    end
    chk("bp_no_access", 64'(rd_pulses * 16 + we_pulses), 64'd16);
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk("bp_released", {62'd0, resp_valid, req_ready}, 64'd1);
    chk("bp_still_no_we", 64'(we_pulses), 64'd0);

    // Reset during a store's ACCESS cycle
    rd_pulses = 0; we_pulses = 0;
    req_valid = 1'b1; req_wr = 1'b1; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 64'h0000_0000_8000_0050; req_wdata = 64'h0000_0000_CAFE_F00D;
    @(posedge clock);
    #1 req_valid = 1'b0;
    @(negedge clock);
    chk("rst_mid_we_access", {63'd0, mem_we_en}, 64'd1);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    chk("rst_mid_ready", {63'd0, req_ready}, 64'd1);
    chk("rst_mid_valid", {63'd0, resp_valid}, 64'd0);
    chk("rst_mid_we_low", {63'd0, mem_we_en}, 64'd0);
    repeat (3) begin
      @(posedge clock);
      @(negedge clock);
      chk("rst_mid_quiet", {63'd0, resp_valid}, 64'd0);
    end
    chk("rst_mid_we_pulses", 64'(we_pulses), 64'd1);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
